// File: rtl/axi_burst_mem_if.sv
// AXI4 bus bundle for axi_burst_mem: AR/R/AW/W/B channels.
// slave modport faces the memory; master modport faces the initiator.
interface axi_burst_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );

    modport master (
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/axi_burst_mem.sv
// AXI4 slave RAM: FIXED/INCR/WRAP bursts, byte strobes, SLVERR, independent
// read/write engines. Ports: aclk, areset (sync, active-high), bus (slave).
// Optional: define AXI_BURST_MEM_WLAST_CHECK_EN to police wlast placement.
module axi_burst_mem #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input logic            aclk,
    input logic            areset,
    axi_burst_mem_if.slave bus
);
    localparam int NB  = DATA_W / 8;
    localparam int OFF = $clog2(NB);
    localparam int DW  = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH * NB);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic [ADDR_W-1:0] nxt(
        input logic [ADDR_W-1:0] a, input logic [2:0] sz,
        input logic [7:0] ln, input logic [1:0] bt);
        logic [ADDR_W-1:0] b;
        logic [ADDR_W-1:0] w;
        logic [ADDR_W-1:0] r;
        b = ADDR_W'(1) << sz;
        w = b * ADDR_W'(ln) + b;
        case (bt)
            2'b01:   r = (a & ~(b - ADDR_W'(1))) + b;
            2'b10:   r = (a & ~(w - ADDR_W'(1))) | ((a + b) & (w - ADDR_W'(1)));
            default: r = a;
        endcase
        return r;
    endfunction

    function automatic logic hdr_bad(
        input logic [2:0] sz, input logic [7:0] ln, input logic [1:0] bt);
        logic wl_ok;
        wl_ok = (ln == 8'd1) || (ln == 8'd3) || (ln == 8'd7) || (ln == 8'd15);
        return (int'(sz) > OFF) || (bt == 2'b11) || ((bt == 2'b10) && !wl_ok);
    endfunction

    function automatic logic oor(input logic [ADDR_W-1:0] a);
        return {1'b0, a} >= LIMIT;
    endfunction

    function automatic logic [DW-1:0] idx(input logic [ADDR_W-1:0] a);
        return a[OFF+DW-1:OFF];
    endfunction

    // ---------------- write engine ----------------
    w_state_t          w_state, w_next;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len, w_cnt;
    logic [2:0]        w_size;
    logic [1:0]        w_burst;
    logic              w_err;
    logic              aw_hs, w_hs, b_hs;
    logic              w_last_beat, w_end, w_bad_last, w_beat_err, w_commit;

    assign aw_hs       = bus.awvalid && bus.awready;
    assign w_hs        = bus.wvalid && bus.wready;
    assign b_hs        = bus.bvalid && bus.bready;
    assign w_last_beat = (w_cnt == w_len);
`ifdef AXI_BURST_MEM_WLAST_CHECK_EN
    assign w_bad_last  = (bus.wlast != w_last_beat);
    assign w_end       = w_last_beat || bus.wlast;
`else
    assign w_bad_last  = 1'b0;
    assign w_end       = w_last_beat;
`endif
    // Error is sticky: once any beat faults, later beats are dropped too.
    assign w_beat_err  = w_err || oor(w_addr) || w_bad_last;
    assign w_commit    = w_hs && !w_beat_err;

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_end) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    assign bus.awready = (w_state == W_IDLE);
    assign bus.wready  = (w_state == W_DATA);
    assign bus.bvalid  = (w_state == W_RESP);
    assign bus.bresp   = ((w_state == W_RESP) && w_err) ? 2'b10 : 2'b00;

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                w_addr  <= bus.awaddr;
                w_len   <= bus.awlen;
                w_size  <= bus.awsize;
                w_burst <= bus.awburst;
                w_cnt   <= '0;
                w_err   <= hdr_bad(bus.awsize, bus.awlen, bus.awburst);
            end else if (w_hs) begin
                w_addr  <= nxt(w_addr, w_size, w_len, w_burst);
                w_cnt   <= w_cnt + 8'd1;
                w_err   <= w_beat_err;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!areset && w_commit) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.wstrb[i])
                    mem[idx(w_addr)][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    r_state_t          r_state, r_next;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len, r_cnt;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic              r_err;
    logic              ar_hs, r_hs, r_last_beat;
    logic              ld;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_bad;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;

    assign ar_hs       = bus.arvalid && bus.arready;
    assign r_hs        = bus.rvalid && bus.rready;
    assign r_last_beat = (r_cnt == r_len);

    // Next beat is fetched on the accepting edge so rvalid can stay high.
    always_comb begin
        r_next  = r_state;
        ld      = 1'b0;
        ld_addr = nxt(r_addr, r_size, r_len, r_burst);
        ld_bad  = r_err || oor(ld_addr);
        case (r_state)
            R_IDLE: if (ar_hs) begin
                r_next  = R_DATA;
                ld      = 1'b1;
                ld_addr = bus.araddr;
                ld_bad  = hdr_bad(bus.arsize, bus.arlen, bus.arburst)
                          || oor(bus.araddr);
            end
            R_DATA: if (r_hs) begin
                if (r_last_beat) r_next = R_IDLE;
                else ld = 1'b1;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign bus.arready = (r_state == R_IDLE);
    assign bus.rvalid  = (r_state == R_DATA);
    assign bus.rlast   = (r_state == R_DATA) && r_last_beat;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_err   <= 1'b0;
            rdata_q <= '0;
            rresp_q <= 2'b00;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                r_len   <= bus.arlen;
                r_size  <= bus.arsize;
                r_burst <= bus.arburst;
                r_cnt   <= '0;
                r_err   <= hdr_bad(bus.arsize, bus.arlen, bus.arburst);
            end else if (r_hs) begin
                r_cnt   <= r_cnt + 8'd1;
            end
            if (ld) begin
                r_addr  <= ld_addr;
                rdata_q <= ld_bad ? '0 : mem[idx(ld_addr)];
                rresp_q <= ld_bad ? 2'b10 : 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_axi_burst_mem.sv
// Directed bench for axi_burst_mem: burst table plus stall and wlast cases.
// Ports driven through an axi_burst_mem_if instance.
module tb_axi_burst_mem;
    typedef logic [0:7][31:0] beats_t;

    typedef struct packed {
        bit          wr;
        logic [31:0] a;
        logic [7:0]  len;
        logic [2:0]  sz;
        logic [1:0]  bt;
        logic [3:0]  st;
        logic [1:0]  rs;
        beats_t      d;
    } vec_t;

    localparam int NV = 19;

    logic aclk = 1'b0;
    logic areset;
    int   total = 0;
    int   bad = 0;

    always #5 aclk = ~aclk;

    axi_burst_mem_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_burst_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024)) dut (
        .aclk  (aclk),
        .areset(areset),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit wr, input logic [31:0] a,
        input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bt,
        input logic [3:0] st, input logic [1:0] rs, input beats_t d);
        vec_t v;
        v.wr = wr; v.a = a; v.len = len; v.sz = sz; v.bt = bt;
        v.st = st; v.rs = rs; v.d = d;
        return v;
    endfunction

    task automatic wr_burst(input logic [31:0] a, input logic [7:0] len,
        input logic [2:0] sz, input logic [1:0] bt, input logic [3:0] st,
        input beats_t d, input int early, input string tag,
        output logic [1:0] resp, output int beats);
        int n;
        bus.awaddr = a; bus.awlen = len; bus.awsize = sz; bus.awburst = bt;
        bus.awvalid = 1'b1;
        n = 0;
        while (!bus.awready && n < 50) begin @(negedge aclk); n++; end
        chk({tag, " aw_timeout"}, 32'(n >= 50), 32'd0);
        @(posedge aclk);
        @(negedge aclk);
        bus.awvalid = 1'b0;
        beats = 0;
        n = 0;
        bus.wstrb = st;
        bus.wvalid = 1'b1;
        while (beats <= int'(len) && beats < 8 && !bus.bvalid && n < 100) begin
            bus.wdata = d[beats];
            bus.wlast = (beats == int'(len)) || (beats == early);
            if (bus.wready) begin
                @(posedge aclk);
                beats++;
            end
            @(negedge aclk);
            n++;
        end
        bus.wvalid = 1'b0;
        bus.wlast = 1'b0;
        n = 0;
        while (!bus.bvalid && n < 50) begin @(negedge aclk); n++; end
        chk({tag, " b_timeout"}, 32'(n >= 50), 32'd0);
        resp = bus.bresp;
        bus.bready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        bus.bready = 1'b0;
    endtask

    task automatic rd_burst(input logic [31:0] a, input logic [7:0] len,
        input logic [2:0] sz, input logic [1:0] bt, input logic [7:0] pat,
        input logic [1:0] ers, input string tag,
        output beats_t got, output int beats);
        int n;
        bit stalled;
        logic [31:0] held;
        got = '0;
        held = '0;
        bus.araddr = a; bus.arlen = len; bus.arsize = sz; bus.arburst = bt;
        bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < 50) begin @(negedge aclk); n++; end
        chk({tag, " ar_timeout"}, 32'(n >= 50), 32'd0);
        @(posedge aclk);
        @(negedge aclk);
        bus.arvalid = 1'b0;
        beats = 0;
        stalled = 1'b0;
        n = 0;
        while (beats <= int'(len) && n < 200) begin
            bus.rready = pat[n % 8];
            if (bus.rvalid) begin
                if (stalled)
                    chk($sformatf("%s stable b%0d", tag, beats), bus.rdata, held);
                if (bus.rready) begin
                    if (beats < 8) got[beats] = bus.rdata;
                    chk($sformatf("%s rresp b%0d", tag, beats),
                        32'(bus.rresp), 32'(ers));
                    chk($sformatf("%s rlast b%0d", tag, beats),
                        32'(bus.rlast), 32'(beats == int'(len)));
                    beats++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = bus.rdata;
                end
            end
            @(posedge aclk);
            @(negedge aclk);
            n++;
        end
        bus.rready = 1'b0;
        chk({tag, " r_timeout"}, 32'(n >= 200), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t   tv [NV];
        vec_t   v;
        beats_t got;
        beats_t wd;
        logic [1:0] rs;
        int     nb;
        string  tag;

        bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);

        chk("rst arready", 32'(bus.arready), 32'd1);
        chk("rst awready", 32'(bus.awready), 32'd1);
        chk("rst wready",  32'(bus.wready),  32'd0);
        chk("rst rvalid",  32'(bus.rvalid),  32'd0);
        chk("rst rlast",   32'(bus.rlast),   32'd0);
        chk("rst rdata",   bus.rdata,        32'd0);
        chk("rst rresp",   32'(bus.rresp),   32'd0);
        chk("rst bvalid",  32'(bus.bvalid),  32'd0);
        chk("rst bresp",   32'(bus.bresp),   32'd0);
        areset = 1'b0;
        @(negedge aclk);

        tv[0]  = mk(1, 32'h100, 3, 2, 2'b01, 4'hF, 2'b00,
            {32'h11, 32'h22, 32'h33, 32'h44, 32'h0, 32'h0, 32'h0, 32'h0});
        tv[1]  = mk(0, 32'h100, 3, 2, 2'b01, 4'hF, 2'b00,
            {32'h11, 32'h22, 32'h33, 32'h44, 32'h0, 32'h0, 32'h0, 32'h0});
        tv[2]  = mk(0, 32'h108, 3, 2, 2'b10, 4'hF, 2'b00,
            {32'h33, 32'h44, 32'h11, 32'h22, 32'h0, 32'h0, 32'h0, 32'h0});
        tv[3]  = mk(1, 32'h200, 0, 2, 2'b01, 4'hF, 2'b00,
            {32'hAABBCCDD, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0});
        tv[4]  = mk(1, 32'h200, 0, 2, 2'b01, 4'h5, 2'b00,
            {32'h11223344, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0});
        tv[5]  = mk(0, 32'h200, 0, 2, 2'b01, 4'hF, 2'b00,
            {32'hAA22CC44, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0});
        tv[6]  = mk(1, 32'h100, 0, 3, 2'b01, 4'hF, 2'b10,
            {32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0});
        tv[7]  = mk(0, 32'h100, 0, 2, 2'b01, 4'hF, 2'b00,
            {32'h11, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0});
        tv[8]  = mk(0, 32'h1000, 3, 2, 2'b01, 4'hF, 2'b10,
            {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0});
        tv[9]  = mk(1, 32'h300, 2, 2, 2'b00, 4'hF, 2'b00,
            {32'h1, 32'h2, 32'h3, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0});
        tv[10] = mk(0, 32'h300, 1, 2, 2'b00, 4'hF, 2'b00,
            {32'h3, 32'h3, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0});
        tv[11] = mk(1, 32'h100, 0, 2, 2'b11, 4'hF, 2'b10,
            {32'h55, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0});
        tv[12] = mk(0, 32'h100, 0, 2, 2'b01, 4'hF, 2'b00,
            {32'h11, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0});
        tv[13] = mk(0, 32'h100, 2, 2, 2'b10, 4'hF, 2'b10,
            {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0});
        tv[14] = mk(1, 32'h502, 1, 2, 2'b01, 4'hF, 2'b00,
            {32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0,
             32'h0, 32'h0, 32'h0, 32'h0});
        tv[15] = mk(0, 32'h500, 1, 2, 2'b01, 4'hF, 2'b00,
            {32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0,
             32'h0, 32'h0, 32'h0, 32'h0});
        tv[16] = mk(1, 32'hFFC, 1, 2, 2'b01, 4'hF, 2'b10,
            {32'hCAFEF00D, 32'h0BADBEEF, 32'h0, 32'h0,
             32'h0, 32'h0, 32'h0, 32'h0});
        tv[17] = mk(0, 32'hFFC, 0, 2, 2'b01, 4'hF, 2'b00,
            {32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0});
        tv[18] = mk(1, 32'h400, 7, 2, 2'b01, 4'hF, 2'b00,
            {32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7});

        for (int i = 0; i < NV; i++) begin
            v = tv[i];
            tag = $sformatf("v%0d", i);
            if (v.wr) begin
                wr_burst(v.a, v.len, v.sz, v.bt, v.st, v.d, -1, tag, rs, nb);
                chk({tag, " bresp"}, 32'(rs), 32'(v.rs));
                chk({tag, " wbeats"}, 32'(nb), 32'(int'(v.len) + 1));
            end else begin
                rd_burst(v.a, v.len, v.sz, v.bt, 8'hFF, v.rs, tag, got, nb);
                chk({tag, " rbeats"}, 32'(nb), 32'(int'(v.len) + 1));
                for (int b = 0; b <= int'(v.len); b++)
                    chk($sformatf("%s rdata b%0d", tag, b), got[b], v.d[b]);
            end
        end

        // Stalled read: rready 1,0,0,1 repeating over an 8-beat burst.
        rd_burst(32'h400, 8'd7, 3'd2, 2'b01, 8'b1001_1001, 2'b00,
                 "stall", got, nb);
        chk("stall rbeats", 32'(nb), 32'd8);
        for (int b = 0; b < 8; b++)
            chk($sformatf("stall rdata b%0d", b), got[b], 32'hA0 + 32'(b));

        // wlast asserted early on beat 1 of a 4-beat burst.
        wd = {32'h1, 32'h2, 32'h3, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0};
        wr_burst(32'h600, 8'd3, 3'd2, 2'b01, 4'hF, wd, 1, "early", rs, nb);
`ifdef AXI_BURST_MEM_WLAST_CHECK_EN
        chk("early bresp", 32'(rs), 32'h2);
        chk("early wbeats", 32'(nb), 32'd2);
`else
        chk("early bresp", 32'(rs), 32'h0);
        chk("early wbeats", 32'(nb), 32'd4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_burst_mem.md
Name: axi_burst_mem

Overview:
- Parametrised AXI4 slave memory that connects to the `slave` modport signal set, generalised in data width, address width and depth.
- Supports FIXED, INCR and WRAP bursts up to 256 beats, with byte strobes, SLVERR reporting and independent read and write engines.
- Used as the default bench target and as on-chip scratch RAM behind the interconnect.

Parameters:
- ADDR_W, 32, byte-address width of araddr/awaddr.
- DATA_W, 32, data width in bits; must be 32, 64 or 128.
- DEPTH, 1024, number of DATA_W-wide words; must be a power of two.
- Derived: NB = DATA_W/8 bytes per word; OFF = log2(NB).

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- araddr  in  ADDR_W  read burst start address.
- arlen  in  8  beats-1.
- arsize  in  3  log2 bytes per beat.
- arburst  in  2  00 FIXED, 01 INCR, 10 WRAP.
- arvalid  in  1  / arready  out  1  AR handshake.
- rdata  out  DATA_W  read data.
- rresp  out  2  00 OKAY, 10 SLVERR.
- rlast  out  1  final read beat.
- rvalid  out  1  / rready  in  1  R handshake.
- awaddr  in  ADDR_W, awlen  in  8, awsize  in  3, awburst  in  2: as AR.
- awvalid  in  1  / awready  out  1  AW handshake.
- wdata  in  DATA_W, wstrb  in  NB  byte enables.
- wlast  in  1  final write beat.
- wvalid  in  1  / wready  out  1  W handshake.
- bresp  out  2  write response.
- bvalid  out  1  / bready  in  1  B handshake.

Behaviour:
- Interface timing: one clock (aclk); reset (areset) is synchronous and active-high.
- Reset values: arready=1, awready=1, wready=0, rvalid=0, rlast=0, rdata=0, rresp=00, bvalid=0, bresp=00.
- Memory contents are not reset. Reset mid-burst abandons the burst; no partial response is issued.
- Handshake rule: a transfer occurs on a rising edge with valid&&ready. Outputs hold stable while valid&&!ready.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On AW handshake, latch addr/len/size/burst, beat count=0, err flag; go to W_DATA (awready=0, wready=1).
  - W_DATA: each W handshake writes bytes where wstrb[i]=1 into word addr[OFF+log2(DEPTH)-1:OFF], unless err is set.
  - After beat len: wready=0, bvalid=1, bresp=err?10:00; go to W_RESP.
  - W_RESP: on B handshake, go to W_IDLE with awready=1 the same edge.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On AR handshake, latch burst and go to R_DATA; rvalid=1 the following cycle (1-cycle latency) with beat 0.
  - R_DATA: on each R handshake, present the next beat next cycle, so back-to-back beats flow when rready=1.
  - rlast=1 on beat len. Handshake on the last beat returns to R_IDLE with arready=1.
  - Data returned when err is set: rdata=0, rresp=10 on every beat.
- Error conditions (err set at address accept): any one of
  - size>OFF;
  - burst=11;
  - WRAP with len not in {1,3,7,15};
  - any beat address >= DEPTH*NB.
  - The out-of-range check is computed per beat and is sticky for write bresp.
- Address generation, per beat, with B = 1<<size:
  - FIXED: address constant.
  - INCR: next = (addr & ~(B-1)) + B, so an unaligned start is aligned after beat 0.
  - WRAP: wrap size W = B*(len+1); next = (addr & ~(W-1)) | ((addr+B) & (W-1)).
  - Arithmetic is ADDR_W wide; carry out is discarded.
- Narrow beats (size<OFF) use data lanes per the address; for writes the master's wstrb is used unmodified.
- Read and write engines are fully independent and may be busy simultaneously.
- Same-word collision: a read beat launched in the same cycle as a W commit returns the old data. The next beat sees the new data.

Optional Feature:
- Macro: AXI_BURST_MEM_WLAST_CHECK_EN.
- With the macro defined:
  - wlast=1 before beat len, or wlast=0 on beat len, sets err; bresp=10.
  - An early wlast terminates the burst immediately (go to W_RESP).
- Without the macro: wlast is ignored and the burst ends purely on the beat count.

Test Plan:
- INCR write len=3, size=2, addr 0x100, data 0x11..0x44, wstrb=F, then INCR read of the same burst -> rdata 0x11,0x22,0x33,0x44, rlast on beat 3, bresp=00, rresp=00.
- WRAP read len=3, size=2, addr 0x108 -> beat addresses 0x108, 0x10C, 0x100, 0x104.
- Write of word 0xAABBCCDD at 0x200, then wstrb=0101 with wdata 0x11223344 -> readback 0xAA22CC44.
- rready toggled 1,0,0,1 during a len=7 read -> no beat lost or duplicated, rdata stable while stalled.
- AW with size=3 on DATA_W=32 -> memory unchanged, bresp=10. AR at DEPTH*NB -> rresp=10 and rdata=0 on every beat.
- Define the macro and drive wlast on beat 1 of len=3 -> burst ends, bresp=10. Without the macro, the same stimulus takes 4 beats and bresp=00.
